button_press_encoder: RTL and testbench



---
 rtl/button_press_encoder_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_press_encoder.sv | 152 +++++++++++++++
 tb/tb_button_press_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/button_press_encoder_pkg.sv
// Shared types and default timing constants for the button press encoder.
// States are 3-bit; tick defaults assume the 100 Hz system clock.
package button_press_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG_HELD  = 3'd3,
    ST_DB_RELEASE = 3'd4
  } state_t;

  localparam int DEFAULT_DEBOUNCE_TICKS = 5;    // 50 ms
  localparam int DEFAULT_LONG_TICKS     = 200;  // 2 s
  localparam int DEFAULT_TRIGGER_TICKS  = 100;  // 1 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/button_press_encoder.sv
// Synchronizes and debounces the user button, classifies short/long presses and
// stretches the long-press trigger so the 1 Hz program-mode FSM can sample it.
module button_press_encoder
  import button_press_encoder_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEFAULT_LONG_TICKS,
  parameter int TRIGGER_TICKS  = DEFAULT_TRIGGER_TICKS
) (
  input  logic clk_100Hz,
  input  logic rst,
  input  logic button_raw,
  output logic button_signal,
  output logic short_press,
  output logic long_press,
  output logic trigger,
  output logic busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_TICKS);
  localparam int HOLD_W = $clog2(LONG_TICKS);
  localparam int TRIG_W = $clog2(TRIGGER_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(TRIGGER_TICKS);

  logic btn_s;

  sync_2ff u_sync (
    .clk  (clk_100Hz),
    .srst (rst),
    .d    (button_raw),
    .q    (btn_s)
  );

  state_t             state_reg, state_next;
  logic [DB_W-1:0]    db_cnt_reg, db_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [TRIG_W-1:0]  trig_cnt_reg, trig_cnt_next;
  logic               was_long_reg, was_long_next;
  logic               button_signal_reg, button_signal_next;
  logic               short_press_reg, short_press_next;
  logic               long_press_reg, long_press_next;
  logic               trigger_reg;
  logic               busy_reg;

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      db_cnt_reg        <= '0;
      hold_cnt_reg      <= '0;
      trig_cnt_reg      <= '0;
      was_long_reg      <= 1'b0;
      button_signal_reg <= 1'b0;
      short_press_reg   <= 1'b0;
      long_press_reg    <= 1'b0;
      trigger_reg       <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      db_cnt_reg        <= db_cnt_next;
      hold_cnt_reg      <= hold_cnt_next;
      trig_cnt_reg      <= trig_cnt_next;
      was_long_reg      <= was_long_next;
      button_signal_reg <= button_signal_next;
      short_press_reg   <= short_press_next;
      long_press_reg    <= long_press_next;
      trigger_reg       <= (trig_cnt_next != '0);
      busy_reg          <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next         = state_reg;
    db_cnt_next        = db_cnt_reg;
    hold_cnt_next      = hold_cnt_reg;
    was_long_next      = was_long_reg;
    button_signal_next = button_signal_reg;
    short_press_next   = 1'b0;
    long_press_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (btn_s) begin
          state_next  = ST_DB_PRESS;
          db_cnt_next = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_next = ST_IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next         = ST_PRESSED;
          button_signal_next = 1'b1;
          hold_cnt_next      = '0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_next    = ST_DB_RELEASE;
          db_cnt_next   = '0;
          was_long_next = 1'b0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next      = ST_LONG_HELD;
          long_press_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_s) begin
          state_next    = ST_DB_RELEASE;
          db_cnt_next   = '0;
          was_long_next = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        // hold_cnt stays frozen here, so a release bounce only delays long_press
        if (btn_s) begin
          state_next = was_long_reg ? ST_LONG_HELD : ST_PRESSED;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next         = ST_IDLE;
          button_signal_next = 1'b0;
          short_press_next   = !was_long_reg;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stretcher runs free of the FSM; a release cannot cut the pulse short.
  always_comb begin
    trig_cnt_next = trig_cnt_reg;
    if (long_press_next) begin
      trig_cnt_next = TRIG_LOAD;
    end else if (trig_cnt_reg != '0) begin
      trig_cnt_next = trig_cnt_reg - 1'b1;
    end
  end

  assign button_signal = button_signal_reg;
  assign short_press   = short_press_reg;
  assign long_press    = long_press_reg;
  assign trigger       = trigger_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_button_press_encoder.sv
// Scoreboard bench: stimulus queues expected output events with edge numbers,
// a negedge monitor matches every observed event against the queue.
module tb_button_press_encoder;

  logic clk_100Hz = 1'b0;
  logic rst;
  logic button_raw;
  logic button_signal, short_press, long_press, trigger, busy;

  button_press_encoder dut (
    .clk_100Hz     (clk_100Hz),
    .rst           (rst),
    .button_raw    (button_raw),
    .button_signal (button_signal),
    .short_press   (short_press),
    .long_press    (long_press),
    .trigger       (trigger),
    .busy          (busy)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int cyc = 0;
  always @(posedge clk_100Hz) cyc <= cyc + 1;

  typedef enum int {EV_BS_RISE, EV_BS_FALL, EV_SHORT, EV_LONG, EV_TRIG_RISE, EV_TRIG_FALL} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void push(input ev_t kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endfunction

  function automatic void match(input ev_t kind);
    int idx = -1;
    for (int i = 0; i < sb_q.size(); i++)
      if (idx < 0 && sb_q[i].kind == kind && sb_q[i].cyc == cyc) idx = i;
    n_checks++;
    if (idx >= 0) begin
      n_pass++;
      sb_q.delete(idx);
    end else begin
      $display("FAIL event %s: observed after edge %0d, required none expected there", kind.name(), cyc);
    end
  endfunction

  logic bs_prev = 1'b0;
  logic tr_prev = 1'b0;

  always @(negedge clk_100Hz) begin
    if (button_signal === 1'b1 && bs_prev == 1'b0) match(EV_BS_RISE);
    if (button_signal === 1'b0 && bs_prev == 1'b1) match(EV_BS_FALL);
    if (short_press === 1'b1) match(EV_SHORT);
    if (long_press === 1'b1) match(EV_LONG);
    if (trigger === 1'b1 && tr_prev == 1'b0) match(EV_TRIG_RISE);
    if (trigger === 1'b0 && tr_prev == 1'b1) match(EV_TRIG_FALL);
    bs_prev = (button_signal === 1'b1);
    tr_prev = (trigger === 1'b1);
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc < cyc) begin
        n_checks++;
        $display("FAIL event %s: not seen by edge %0d, required after edge %0d",
                 sb_q[i].kind.name(), cyc, sb_q[i].cyc);
        sb_q.delete(i);
      end
    end
  end

  function automatic void check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b (edge %0d)", name, act, exp, cyc);
  endfunction

  function automatic void check_idle(input string tag);
    check_bit({tag, ".button_signal"}, button_signal, 1'b0);
    check_bit({tag, ".short_press"}, short_press, 1'b0);
    check_bit({tag, ".long_press"}, long_press, 1'b0);
    check_bit({tag, ".trigger"}, trigger, 1'b0);
    check_bit({tag, ".busy"}, busy, 1'b0);
  endfunction

  // Return at a negedge such that the next rising edge is edge number t.
  task automatic go_to(input int t);
    while (cyc < t - 1) @(negedge clk_100Hz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  int e0;

  initial begin
    rst        = 1'b1;
    button_raw = 1'b1;

    // 1: reset with button held, then re-debounce
    repeat (3) begin
      @(negedge clk_100Hz);
      check_idle("reset");
    end
    rst = 1'b0;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    go_to(e0 + 20);
    button_raw = 1'b0;
    push(EV_BS_FALL, e0 + 27);
    push(EV_SHORT, e0 + 27);
    go_to(e0 + 40);
    check_idle("s1_end");

    // 2: 3-cycle blip is rejected
    button_raw = 1'b1;
    e0 = cyc + 1;
    go_to(e0 + 3);
    button_raw = 1'b0;
    go_to(e0 + 4);
    check_bit("s2.busy_mid", busy, 1'b1);
    go_to(e0 + 6);
    check_idle("s2_end");

    // 3: short press of 50 cycles
    go_to(cyc + 5);
    button_raw = 1'b1;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    go_to(e0 + 30);
    check_bit("s3.busy_mid", busy, 1'b1);
    check_bit("s3.bs_mid", button_signal, 1'b1);
    go_to(e0 + 50);
    button_raw = 1'b0;
    push(EV_BS_FALL, e0 + 57);
    push(EV_SHORT, e0 + 57);
    go_to(e0 + 70);
    check_idle("s3_end");

    // 4: long press of 300 cycles
    button_raw = 1'b1;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    push(EV_LONG, e0 + 207);
    push(EV_TRIG_RISE, e0 + 207);
    push(EV_TRIG_FALL, e0 + 307);
    go_to(e0 + 300);
    button_raw = 1'b0;
    push(EV_BS_FALL, e0 + 307);
    go_to(e0 + 320);
    check_idle("s4_end");

    // 5: 2-cycle glitch at cycle 100 costs three hold edges
    button_raw = 1'b1;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    push(EV_LONG, e0 + 210);
    push(EV_TRIG_RISE, e0 + 210);
    push(EV_TRIG_FALL, e0 + 310);
    go_to(e0 + 100);
    button_raw = 1'b0;
    go_to(e0 + 102);
    button_raw = 1'b1;
    go_to(e0 + 300);
    button_raw = 1'b0;
    push(EV_BS_FALL, e0 + 307);
    go_to(e0 + 330);
    check_idle("s5_end");

    // 6: reset at trigger cycle 40 with the button still held
    button_raw = 1'b1;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    push(EV_LONG, e0 + 207);
    push(EV_TRIG_RISE, e0 + 207);
    go_to(e0 + 247);
    rst = 1'b1;
    push(EV_BS_FALL, e0 + 247);
    push(EV_TRIG_FALL, e0 + 247);
    go_to(e0 + 248);
    check_idle("s6_rst");
    rst = 1'b0;
    e0 = cyc + 1;
    push(EV_BS_RISE, e0 + 7);
    push(EV_LONG, e0 + 207);
    push(EV_TRIG_RISE, e0 + 207);
    push(EV_TRIG_FALL, e0 + 307);
    go_to(e0 + 250);
    button_raw = 1'b0;
    push(EV_BS_FALL, e0 + 257);
    go_to(e0 + 330);
    check_idle("s6_end");

    go_to(cyc + 3);
    @(negedge clk_100Hz);
    foreach (sb_q[i]) begin
      n_checks++;
      $display("FAIL event %s: still pending at end, required after edge %0d",
               sb_q[i].kind.name(), sb_q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
